// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hard-wired CPU controller:
// opcodes, ALU ops, datapath bit indices, states and decode helpers.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'd3;
  localparam logic [4:0] ALU_SUB = 5'd4;
  localparam logic [4:0] ALU_AND = 5'd5;
  localparam logic [4:0] ALU_OR  = 5'd6;
  localparam logic [4:0] ALU_INC = 5'd14;

  localparam int EN_ZIN   = 18;
  localparam int EN_YIN   = 19;
  localparam int EN_PCIN  = 20;
  localparam int EN_MDRIN = 21;
  localparam int EN_IRIN  = 24;
  localparam int EN_MARIN = 25;
  localparam int EN_CONIN = 27;

  localparam int BS_GR  = 0;
  localparam int BS_ZLO = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;
  localparam int BS_C   = 23;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_ADDI, C_LD, C_ST,
    C_BR, C_JR, C_NOP, C_HALT
  } cls_e;

  function automatic cls_e classify(
    input logic [4:0] op
  );
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR: return C_ALU;
      OP_ADDI:       return C_ADDI;
      OP_LD:         return C_LD;
      OP_ST:         return C_ST;
      OP_BR:         return C_BR;
      OP_JR:         return C_JR;
      OP_NOP:        return C_NOP;
      OP_HALT:       return C_HALT;
      default:       return C_HALT;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(
    input logic [4:0] op
  );
    unique case (1'b1)
      op == OP_SUB: return ALU_SUB;
      op == OP_AND: return ALU_AND;
      op == OP_OR:  return ALU_OR;
      default:      return ALU_ADD;
    endcase
  endfunction

  function automatic logic mem_step(
    input state_e s,
    input cls_e   c
  );
    return (s == S_T1) ||
           (s == S_T6 && c == C_LD) ||
           (s == S_T7 && c == C_ST);
  endfunction

endpackage

// File: rtl/ctrl_mem_wait.sv
// Hold counter for memory steps: loads MEM_LAT-1 on
// entry, counts down, flags the final cycle.
module ctrl_mem_wait #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  output logic last
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      cnt <= '0;
    else if (start)
      cnt <= 4'(MEM_LAT - 1);
    else if (cnt != '0)
      cnt <= cnt - 4'd1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/control_unit.sv
// Hard-wired Moore controller sequencing fetch and
// execute steps T0-T7 of each instruction.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        instr_done,
  output logic        halted
);

  state_e state, nxt, fin;
  cls_e   cls;
  logic   start, mem_last, mem_first;
  logic   unused_ir;

  assign cls       = classify(ir[31:27]);
  assign unused_ir = ^ir[26:0];
  assign fin       = run ? S_T0 : S_IDLE;
  assign start     = (nxt != state) &&
                     mem_step(nxt, cls);

  ctrl_mem_wait #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .last  (mem_last)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      mem_first <= 1'b0;
    end else begin
      state     <= nxt;
      mem_first <= start;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (run) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   if (mem_last) nxt = S_T2;
      S_T2:   nxt = S_T3;
      S_T3: begin
        case (cls)
          C_HALT:       nxt = S_HALT;
          C_JR, C_NOP:  nxt = fin;
          default:      nxt = S_T4;
        endcase
      end
      S_T4:   nxt = S_T5;
      S_T5: begin
        if (cls == C_ALU || cls == C_ADDI)
          nxt = fin;
        else
          nxt = S_T6;
      end
      S_T6: begin
        case (cls)
          C_LD:    if (mem_last) nxt = S_T7;
          C_ST:    nxt = S_T7;
          default: nxt = fin;
        endcase
      end
      S_T7: begin
        if (cls != C_ST || mem_last)
          nxt = fin;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Control_Signals = '0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    MD_Read    = 1'b0;
    ReadRAM    = 1'b0;
    WriteRAM   = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_T0: begin
        busSelect[BS_PC]  = 1'b1;
        enable[EN_MARIN]  = 1'b1;
        enable[EN_ZIN]    = 1'b1;
        Control_Signals   = ALU_INC;
      end
      S_T1: begin
        busSelect[BS_ZLO] = 1'b1;
        enable[EN_PCIN]   = mem_first;
        enable[EN_MDRIN]  = 1'b1;
        MD_Read = 1'b1;
        ReadRAM = 1'b1;
      end
      S_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IRIN]   = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU, C_ADDI, C_LD, C_ST: begin
            Grb   = 1'b1;
            Rout  = (cls == C_ALU || cls == C_ADDI);
            BAout = (cls == C_LD || cls == C_ST);
            busSelect[BS_GR] = 1'b1;
            enable[EN_YIN]   = 1'b1;
          end
          C_BR, C_JR: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            busSelect[BS_GR]  = 1'b1;
            enable[EN_CONIN]  = (cls == C_BR);
            enable[EN_PCIN]   = (cls == C_JR);
            instr_done        = (cls == C_JR);
          end
          C_NOP:   instr_done = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU: begin
            Grc  = 1'b1;
            Rout = 1'b1;
            busSelect[BS_GR] = 1'b1;
            enable[EN_ZIN]   = 1'b1;
            Control_Signals  = alu_of(ir[31:27]);
          end
          C_BR: begin
            busSelect[BS_PC] = 1'b1;
            enable[EN_YIN]   = 1'b1;
          end
          default: begin
            busSelect[BS_C] = 1'b1;
            enable[EN_ZIN]  = 1'b1;
            Control_Signals = ALU_ADD;
          end
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_ADDI: begin
            busSelect[BS_ZLO] = 1'b1;
            Gra = 1'b1;
            Rin = 1'b1;
            instr_done = 1'b1;
          end
          C_BR: begin
            busSelect[BS_C] = 1'b1;
            enable[EN_ZIN]  = 1'b1;
            Control_Signals = ALU_ADD;
          end
          default: begin
            busSelect[BS_ZLO] = 1'b1;
            enable[EN_MARIN]  = 1'b1;
          end
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            MD_Read = 1'b1;
            ReadRAM = 1'b1;
            enable[EN_MDRIN] = 1'b1;
          end
          C_ST: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            busSelect[BS_GR] = 1'b1;
            enable[EN_MDRIN] = 1'b1;
          end
          default: begin
            busSelect[BS_ZLO] = con_ff;
            enable[EN_PCIN]   = con_ff;
            instr_done = 1'b1;
          end
        endcase
      end
      S_T7: begin
        if (cls == C_ST) begin
          WriteRAM   = 1'b1;
          instr_done = mem_last;
        end else begin
          busSelect[BS_MDR] = 1'b1;
          Gra = 1'b1;
          Rin = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit, run
// against three instances with MEM_LAT = 1, 2, 3.
module tb_control_unit;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bus;
    logic [4:0]  cs;
    logic [8:0]  fl;
    logic        d;
    logic        h;
  } obs_t;

  typedef struct {
    int          lat;
    logic        rst;
    logic        run;
    logic [31:0] ir;
    logic        con;
    obs_t        exp;
  } vec_t;

  localparam logic [8:0] F_GRA  = 9'b100000000;
  localparam logic [8:0] F_GRB  = 9'b010000000;
  localparam logic [8:0] F_GRC  = 9'b001000000;
  localparam logic [8:0] F_RIN  = 9'b000100000;
  localparam logic [8:0] F_ROUT = 9'b000010000;
  localparam logic [8:0] F_BA   = 9'b000001000;
  localparam logic [8:0] F_MDR  = 9'b000000100;
  localparam logic [8:0] F_RD   = 9'b000000010;
  localparam logic [8:0] F_WR   = 9'b000000001;

  localparam logic [31:0] I_ADD  = 32'h1891_8000;
  localparam logic [31:0] I_SUB  = 32'h2091_8000;
  localparam logic [31:0] I_LD   = 32'h0090_0000;
  localparam logic [31:0] I_ST   = 32'h1090_0000;
  localparam logic [31:0] I_BR   = 32'h9080_0000;
  localparam logic [31:0] I_JR   = 32'hA080_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  logic clk, clr, run, con;
  logic [31:0] ir;

  logic [31:0] en_o  [1:3];
  logic [31:0] bus_o [1:3];
  logic [4:0]  cs_o  [1:3];
  logic gra [1:3], grb [1:3], grc [1:3];
  logic rin [1:3], rout [1:3], baout [1:3];
  logic mdr [1:3], rdr [1:3], wrr [1:3];
  logic done [1:3], hlt [1:3];

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    control_unit #(.MEM_LAT(g)) u_dut (
      .clk             (clk),
      .clr             (clr),
      .run             (run),
      .ir              (ir),
      .con_ff          (con),
      .enable          (en_o[g]),
      .busSelect       (bus_o[g]),
      .Control_Signals (cs_o[g]),
      .Gra             (gra[g]),
      .Grb             (grb[g]),
      .Grc             (grc[g]),
      .Rin             (rin[g]),
      .Rout            (rout[g]),
      .BAout           (baout[g]),
      .MD_Read         (mdr[g]),
      .ReadRAM         (rdr[g]),
      .WriteRAM        (wrr[g]),
      .instr_done      (done[g]),
      .halted          (hlt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  function automatic obs_t o(
    input logic [31:0] en, input logic [31:0] bus,
    input logic [4:0] cs, input logic [8:0] fl,
    input logic d, input logic h
  );
    obs_t r;
    r.en = en; r.bus = bus; r.cs = cs;
    r.fl = fl; r.d = d; r.h = h;
    return r;
  endfunction

  function automatic obs_t get(input int k);
    obs_t r;
    r.en  = en_o[k];
    r.bus = bus_o[k];
    r.cs  = cs_o[k];
    r.fl  = {gra[k], grb[k], grc[k], rin[k], rout[k],
             baout[k], mdr[k], rdr[k], wrr[k]};
    r.d   = done[k];
    r.h   = hlt[k];
    return r;
  endfunction

  task automatic chk(input string nm, input int k,
                     input obs_t e);
    obs_t g;
    g = get(k);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s L%0d: got en=%h bus=%h cs=%0d fl=%b d=%b h=%b want en=%h bus=%h cs=%0d fl=%b d=%b h=%b",
        nm, k, g.en, g.bus, g.cs, g.fl, g.d, g.h,
        e.en, e.bus, e.cs, e.fl, e.d, e.h);
    end
  endtask

  task automatic add(input int lat, input logic rst,
                     input logic rn, input logic [31:0] i,
                     input logic c, input obs_t e);
    vec_t v;
    v.lat = lat; v.rst = rst; v.run = rn;
    v.ir = i; v.con = c; v.exp = e;
    tbl.push_back(v);
  endtask

  obs_t Z, H, T0, T1A, T1B, T2;
  obs_t A3, A4, A5, U4, M3, M4, M5;
  obs_t L6, L7, S6, S7A, S7B;
  obs_t B3, B4, B5, B6T, B6F, J3;

  initial begin
    clr = 1'b1; run = 1'b0; ir = '0; con = 1'b0;
    Z   = o(0, 0, 0, 0, 0, 0);
    H   = o(0, 0, 0, 0, 0, 1);
    T0  = o(32'h0204_0000, 32'h0010_0000, 14, 0, 0, 0);
    T1A = o(32'h0030_0000, 32'h0008_0000, 0, F_MDR|F_RD, 0, 0);
    T1B = o(32'h0020_0000, 32'h0008_0000, 0, F_MDR|F_RD, 0, 0);
    T2  = o(32'h0100_0000, 32'h0020_0000, 0, 0, 0, 0);
    A3  = o(32'h0008_0000, 1, 0, F_GRB|F_ROUT, 0, 0);
    A4  = o(32'h0004_0000, 1, 3, F_GRC|F_ROUT, 0, 0);
    U4  = o(32'h0004_0000, 1, 4, F_GRC|F_ROUT, 0, 0);
    A5  = o(0, 32'h0008_0000, 0, F_GRA|F_RIN, 1, 0);
    M3  = o(32'h0008_0000, 1, 0, F_GRB|F_BA, 0, 0);
    M4  = o(32'h0004_0000, 32'h0080_0000, 3, 0, 0, 0);
    M5  = o(32'h0200_0000, 32'h0008_0000, 0, 0, 0, 0);
    L6  = o(32'h0020_0000, 0, 0, F_MDR|F_RD, 0, 0);
    L7  = o(0, 32'h0020_0000, 0, F_GRA|F_RIN, 1, 0);
    S6  = o(32'h0020_0000, 1, 0, F_GRA|F_ROUT, 0, 0);
    S7A = o(0, 0, 0, F_WR, 0, 0);
    S7B = o(0, 0, 0, F_WR, 1, 0);
    B3  = o(32'h0800_0000, 1, 0, F_GRA|F_ROUT, 0, 0);
    B4  = o(32'h0008_0000, 32'h0010_0000, 0, 0, 0, 0);
    B5  = o(32'h0004_0000, 32'h0080_0000, 3, 0, 0, 0);
    B6T = o(32'h0010_0000, 32'h0008_0000, 0, 0, 1, 0);
    B6F = o(0, 0, 0, 0, 1, 0);
    J3  = o(32'h0010_0000, 1, 0, F_GRA|F_ROUT, 1, 0);

    // add, MEM_LAT=1: 6 cycles then straight back to T0
    add(1, 1, 1, I_ADD, 0, T0);  add(1, 0, 1, I_ADD, 0, T1A);
    add(1, 0, 1, I_ADD, 0, T2);  add(1, 0, 1, I_ADD, 0, A3);
    add(1, 0, 1, I_ADD, 0, A4);  add(1, 0, 1, I_ADD, 0, A5);
    add(1, 0, 1, I_ADD, 0, T0);
    // ld, MEM_LAT=3: 12 cycles
    add(3, 1, 1, I_LD, 0, T0);   add(3, 0, 1, I_LD, 0, T1A);
    add(3, 0, 1, I_LD, 0, T1B);  add(3, 0, 1, I_LD, 0, T1B);
    add(3, 0, 1, I_LD, 0, T2);   add(3, 0, 1, I_LD, 0, M3);
    add(3, 0, 1, I_LD, 0, M4);   add(3, 0, 1, I_LD, 0, M5);
    add(3, 0, 1, I_LD, 0, L6);   add(3, 0, 1, I_LD, 0, L6);
    add(3, 0, 1, I_LD, 0, L6);   add(3, 0, 1, I_LD, 0, L7);
    add(3, 0, 1, I_LD, 0, T0);
    // st, MEM_LAT=2: 10 cycles
    add(2, 1, 1, I_ST, 0, T0);   add(2, 0, 1, I_ST, 0, T1A);
    add(2, 0, 1, I_ST, 0, T1B);  add(2, 0, 1, I_ST, 0, T2);
    add(2, 0, 1, I_ST, 0, M3);   add(2, 0, 1, I_ST, 0, M4);
    add(2, 0, 1, I_ST, 0, M5);   add(2, 0, 1, I_ST, 0, S6);
    add(2, 0, 1, I_ST, 0, S7A);  add(2, 0, 1, I_ST, 0, S7B);
    add(2, 0, 1, I_ST, 0, T0);
    // br taken, br not taken, jr back to back
    add(1, 1, 1, I_BR, 1, T0);   add(1, 0, 1, I_BR, 1, T1A);
    add(1, 0, 1, I_BR, 1, T2);   add(1, 0, 1, I_BR, 1, B3);
    add(1, 0, 1, I_BR, 1, B4);   add(1, 0, 1, I_BR, 1, B5);
    add(1, 0, 1, I_BR, 1, B6T);  add(1, 0, 1, I_BR, 0, T0);
    add(1, 0, 1, I_BR, 0, T1A);  add(1, 0, 1, I_BR, 0, T2);
    add(1, 0, 1, I_BR, 0, B3);   add(1, 0, 1, I_BR, 0, B4);
    add(1, 0, 1, I_BR, 0, B5);   add(1, 0, 1, I_BR, 0, B6F);
    add(1, 0, 1, I_JR, 0, T0);   add(1, 0, 1, I_JR, 0, T1A);
    add(1, 0, 1, I_JR, 0, T2);   add(1, 0, 1, I_JR, 0, J3);
    add(1, 0, 1, I_JR, 0, T0);
    // halt holds with run high
    add(1, 1, 1, I_HALT, 0, T0); add(1, 0, 1, I_HALT, 0, T1A);
    add(1, 0, 1, I_HALT, 0, T2); add(1, 0, 1, I_HALT, 0, Z);
    add(1, 0, 1, I_HALT, 0, H);  add(1, 0, 1, I_HALT, 0, H);
    add(1, 0, 1, I_HALT, 0, H);
    // sub with run dropped mid-instruction: ends in IDLE
    add(1, 1, 1, I_SUB, 0, T0);  add(1, 0, 0, I_SUB, 0, T1A);
    add(1, 0, 0, I_SUB, 0, T2);  add(1, 0, 0, I_SUB, 0, A3);
    add(1, 0, 0, I_SUB, 0, U4);  add(1, 0, 0, I_SUB, 0, A5);
    add(1, 0, 0, I_SUB, 0, Z);   add(1, 0, 0, I_SUB, 0, Z);
    add(1, 0, 1, I_SUB, 0, T0);

    #1 clr = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 3; k++) chk("reset", k, Z);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
      end
      run = tbl[i].run;
      ir  = tbl[i].ir;
      con = tbl[i].con;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), tbl[i].lat, tbl[i].exp);
    end

    // clr pulsed low during T4 of an add
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1; run = 1'b1; ir = I_ADD;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_clr_t4", 1, A4);
    clr = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) chk("clr_mid", k, Z);
    @(posedge clk);
    #1;
    chk("clr_hold", 1, Z);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("after_clr", 1, T0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hard-wired Moore controller that sequences the CPU datapath through the fetch and execute steps (T0–T7) of each instruction. It drives the datapath's `enable`, `busSelect`, `Control_Signals` and register-select/memory strobes from the instruction register and the CON flip-flop. It replaces the hand-scripted per-state stimulus used in the phase benches with one step per clock.

## Interface
- `MEM_LAT`, default 1: clocks each memory step (RAM read/write) is held; legal range 1–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `run`  in  1  permits instruction issue; sampled only when entering T0.
- `ir`  in  32  datapath IR: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- `con_ff`  in  1  CON flip-flop output (branch condition met).
- `enable`  out  32  register load enables: [18] Zin, [19] Yin, [20] PCin, [21] MDRin, [24] IRin, [25] MARin, [27] CONin; all other bits 0.
- `busSelect`  out  32  bus source: [0] Gr-selected register, [19] ZLow, [20] PC, [21] MDR, [23] C sign-extended; at most one bit set.
- `Control_Signals`  out  5  ALU op.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`  out  1 each  select/encode strobes.
- `MD_Read`, `ReadRAM`, `WriteRAM`  out  1 each  MDR mux select and RAM strobes.
- `instr_done`  out  1  one-cycle pulse in the last step of every instruction.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, T0–T7, HALT. Outputs decode from the registered state plus `ir` and `con_ff` only (Moore). Any output not listed for a step is 0.
- **IDLE**
  - Go to T0 when `run` = 1.
  - On completing any instruction, go to T0 if `run` = 1, else IDLE.
- **Fetch**
  - T0: `busSelect[20]`, `enable[25]`, `Control_Signals` = INC (14), `enable[18]`.
  - T1: `busSelect[19]`, `enable[20]`, `MD_Read`, `ReadRAM`, `enable[21]`. Held `MEM_LAT` cycles; `enable[20]` asserted in the first cycle only.
  - T2: `busSelect[21]`, `enable[24]`.
- **R-type (add/sub/and/or)**
  - T3: `Grb`, `Rout`, `busSelect[0]`, `enable[19]`.
  - T4: `Grc`, `Rout`, `busSelect[0]`, op, `enable[18]`.
  - T5: `busSelect[19]`, `Gra`, `Rin`, done.
- **addi**
  - T3: as R-type T3.
  - T4: `busSelect[23]`, ADD, `enable[18]`.
  - T5: as R-type T5.
- **ld / st**
  - T3: `Grb`, `BAout`, `busSelect[0]`, `enable[19]`.
  - T4: `busSelect[23]`, ADD, `enable[18]`.
  - T5: `busSelect[19]`, `enable[25]`.
  - ld T6: `MD_Read`, `ReadRAM`, `enable[21]`, held `MEM_LAT` cycles.
  - ld T7: `busSelect[21]`, `Gra`, `Rin`, done.
  - st T6: `Gra`, `Rout`, `busSelect[0]`, `enable[21]`, `MD_Read` = 0.
  - st T7: `WriteRAM`, held `MEM_LAT` cycles, done in the last cycle.
- **br**
  - T3: `Gra`, `Rout`, `busSelect[0]`, `enable[27]`.
  - T4: `busSelect[20]`, `enable[19]`.
  - T5: `busSelect[23]`, ADD, `enable[18]`.
  - T6: if `con_ff` = 1, `busSelect[19]` and `enable[20]`; otherwise no enables. Done either way.
- **jr**: T3: `Gra`, `Rout`, `busSelect[0]`, `enable[20]`, done.
- **nop**: done in T3 with no other outputs.
- **halt, and any undefined opcode**: T3 → HALT. HALT holds with `halted` = 1 until `clr`.

## Timing
- One step per clock, except held memory steps. Outputs are stable for the whole cycle; the datapath captures on the following rising edge.
- Instruction length in clocks:
  - R-type/addi: 5 + `MEM_LAT`.
  - ld: 6 + 2·`MEM_LAT`.
  - st: 6 + 2·`MEM_LAT`.
  - br: 6 + `MEM_LAT`.
  - jr/nop: 3 + `MEM_LAT`.
- `ir` is sampled from T3 onward. It is valid because IRin captures at the end of T2.
- `con_ff` is sampled in T6. CONin loaded at the end of T3, so the value is settled.
- Memory hold counter: 4 bits, loaded with `MEM_LAT`−1 on entry, decremented each cycle; the step exits when the counter is 0.
- Reset: `clr` low forces IDLE and zeroes every output immediately, in any state including mid-instruction or a held memory step. Leaving reset requires one edge with `clr` high.
- `run` deasserted mid-instruction does not abort it; it is acted on only at the T0 decision point.

## Structure
- Package `cpu_ctrl_pkg`:
  - Opcodes: ld 00000, addi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, br 10010, jr 10100, nop 11010, halt 11011.
  - ALU ops: ADD 3, SUB 4, AND 5, OR 6, INC 14.
  - Enable/busSelect bit-index constants and the state enum.
- One sub-module, `ctrl_mem_wait`: the `MEM_LAT` hold counter, with inputs `start`/`clk`/`clr` and output `last`.

## Test plan
- Reset and fetch: `clr` = 0 → all outputs 0. Release with `run` = 1 → first T0 shows `busSelect` = 32'h0010_0000, `enable` = 32'h0204_0000, `Control_Signals` = 14.
- add r1,r2,r3 (`ir` = 32'h1891_8000), `MEM_LAT` = 1 → 6 cycles. T5: `busSelect[19]`, `Gra`, `Rin`, `instr_done` = 1. Next state is T0.
- br with `con_ff` = 1 → T6 `enable` = 32'h0010_0000. With `con_ff` = 0 → T6 `enable` = 0. Both pulse `instr_done`.
- ld, `MEM_LAT` = 3 → T1 and T6 each hold 3 cycles with `ReadRAM` = 1; instruction takes 12 cycles. T7 asserts `Gra`, `Rin`, `busSelect[21]`.
- st, `MEM_LAT` = 2 → T6 has `enable[21]` = 1 and `MD_Read` = 0. T7 has `WriteRAM` = 1 for 2 cycles, with `instr_done` in the second.
- Control events:
  - Opcode 11011 → HALT, `halted` = 1, stays there with `run` = 1.
  - `clr` pulsed low mid-T4 of an add → outputs 0 the same cycle, state IDLE.
  - `run` = 0 at instruction end → IDLE.
